// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of a multicycle MIPS-style datapath.
//
// The controller walks each instruction through FETCH, DECODE and a short
// opcode-specific tail of execute / memory / write-back states. All datapath
// selects and strobes are Moore outputs of the current state plus the opcode
// latched in DECODE. The exceptions are the completion-gated strobes (irwrite,
// pcwrite in FETCH, memwrite in MEMWR) and illegal_op, which depends on the
// live opcode in DECODE.
//
// Handshake: a memory state (FETCH, MEMRD, MEMWR) keeps mem_req high. The
// access completes in the cycle mem_req and mem_ready are both high, and the
// FSM leaves the state on that edge. With MEM_HS=0 every memory state
// completes in its first cycle and mem_ready is ignored.
//
// Parameters:
//   OP_W     opcode width (default 6)
//   ALUOP_W  aluop width (default 3)
//   MEM_HS   1: memory states wait on mem_ready; 0: single-cycle memory states
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   op                instruction-register opcode, sampled in DECODE
//   mem_ready         memory completion for the current mem_req cycle
//   mem_req           memory access request
//   irwrite, pcwrite, iord, memwrite, memtoreg, regdst, regwrite, alusrca
//                     datapath strobes / selects
//   alusrcb           00 reg B, 01 const 4, 10 sign-ext imm, 11 imm << 2
//   pcsrc             00 ALU result, 01 ALUOut, 10 jump target
//   beq, bne          conditional PC-write enables
//   aluop             ALU operation class
//   illegal_op        one-cycle pulse on an undefined opcode in DECODE
//   busy              high in every state except FETCH
//   state_dbg         current state encoding, for observation only

module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int MEM_HS  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               iord,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               beq,
  output logic               bne,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic               busy,
  output logic [3:0]         state_dbg
);

  // ALU operation classes, matching the ALU_* encodings shared with the ALU
  // decoder.
  localparam logic [ALUOP_W-1:0] ALU_AND    = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_OR     = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_NO_USE = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_SUB    = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT    = ALUOP_W'(3'b111);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              mem_done;
  logic [ALUOP_W-1:0] imm_alu;

  assign state_dbg = state_q;

  // Completion of the current memory cycle. With MEM_HS=0 memory states
  // always finish in one cycle, so mem_ready never matters.
  assign mem_done = (MEM_HS != 0) ? mem_ready : 1'b1;

  // ALU class for the immediate group, from the opcode latched in DECODE.
  // IMMEX and IMMWB both use it so the result stays stable through write-back.
  always_comb begin
    imm_alu = ALU_ADD;
    case (op_q)
      OP_ORI:  imm_alu = ALU_OR;
      OP_ANDI: imm_alu = ALU_AND;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_req    = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    beq        = 1'b0;
    bne        = 1'b0;
    aluop      = ALU_ADD;
    illegal_op = 1'b0;
    busy       = (state_q != S_FETCH);

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // PC+4 and the instruction register update only once the fetch lands.
        irwrite = mem_done;
        pcwrite = mem_done;
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        alusrcb = 2'b11;
        op_d    = op;
        case (op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_REX;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: state_d = S_IMMEX;
          OP_J:                              state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = mem_done;
        if (mem_done) state_d = S_FETCH;
      end
      S_REX: begin
        // The ALU decodes funct itself for R-type.
        alusrca = 1'b1;
        aluop   = ALU_NO_USE;
        state_d = S_RWB;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        beq     = (op_q == OP_BEQ);
        bne     = (op_q == OP_BNE);
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = imm_alu;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        aluop    = imm_alu;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = S_FETCH;
      end
      default: begin
        // Unused encodings: all strobes stay at their defaults, go home.
        state_d = S_FETCH;
      end
    endcase

    // Nothing may be written or requested while reset is held.
    if (reset) begin
      mem_req    = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      beq        = 1'b0;
      bne        = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Two instances run side by side: dut_h waits on
// mem_ready (MEM_HS=1), dut_z uses single-cycle memory states (MEM_HS=0).
// Each instruction is modelled as a plan of steps built in DECODE from the
// opcode's class; memory steps stall until their access completes. Expected
// outputs per step come from the control table for that step.
module tb_multicycle_ctrl;

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_NOUSE = 3'b011, A_SUB = 3'b110, A_SLT = 3'b111;
  localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100,
                         O_BNE = 6'b000101, O_ADDI = 6'b001000, O_SLTI = 6'b001010,
                         O_ANDI = 6'b001100, O_ORI = 6'b001101, O_LW = 6'b100011,
                         O_SW = 6'b101011, O_BAD = 6'b111111;
  // Bench step codes (independent of the design's encoding).
  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5,
                 S_RX = 6, S_RWB = 7, S_BR = 8, S_IX = 9, S_IWB = 10, S_J = 11;
  // Bit positions in the packed output vector.
  localparam int B_MEMREQ = 19, B_IRWRITE = 18, B_PCWRITE = 17, B_MEMWRITE = 15,
                 B_MEMTOREG = 14, B_REGWRITE = 12, B_BEQ = 6, B_BNE = 5,
                 B_ILLEGAL = 1, B_BUSY = 0;

  logic       clk, reset;
  logic [5:0] op_h, op_z;
  logic       ready_h, ready_z;

  logic mem_req_h, irwrite_h, pcwrite_h, iord_h, memwrite_h, memtoreg_h, regdst_h;
  logic regwrite_h, alusrca_h, beq_h, bne_h, illegal_h, busy_h;
  logic [1:0] alusrcb_h, pcsrc_h;
  logic [2:0] aluop_h;
  logic [3:0] sdbg_h;
  logic mem_req_z, irwrite_z, pcwrite_z, iord_z, memwrite_z, memtoreg_z, regdst_z;
  logic regwrite_z, alusrca_z, beq_z, bne_z, illegal_z, busy_z;
  logic [1:0] alusrcb_z, pcsrc_z;
  logic [2:0] aluop_z;
  logic [3:0] sdbg_z;

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .MEM_HS(1)) dut_h (
    .clk(clk), .reset(reset), .op(op_h), .mem_ready(ready_h),
    .mem_req(mem_req_h), .irwrite(irwrite_h), .pcwrite(pcwrite_h), .iord(iord_h),
    .memwrite(memwrite_h), .memtoreg(memtoreg_h), .regdst(regdst_h),
    .regwrite(regwrite_h), .alusrca(alusrca_h), .alusrcb(alusrcb_h),
    .pcsrc(pcsrc_h), .beq(beq_h), .bne(bne_h), .aluop(aluop_h),
    .illegal_op(illegal_h), .busy(busy_h), .state_dbg(sdbg_h)
  );

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .MEM_HS(0)) dut_z (
    .clk(clk), .reset(reset), .op(op_z), .mem_ready(ready_z),
    .mem_req(mem_req_z), .irwrite(irwrite_z), .pcwrite(pcwrite_z), .iord(iord_z),
    .memwrite(memwrite_z), .memtoreg(memtoreg_z), .regdst(regdst_z),
    .regwrite(regwrite_z), .alusrca(alusrca_z), .alusrcb(alusrcb_z),
    .pcsrc(pcsrc_z), .beq(beq_z), .bne(bne_z), .aluop(aluop_z),
    .illegal_op(illegal_z), .busy(busy_z), .state_dbg(sdbg_z)
  );

  wire [19:0] act_h = {mem_req_h, irwrite_h, pcwrite_h, iord_h, memwrite_h, memtoreg_h,
                       regdst_h, regwrite_h, alusrca_h, alusrcb_h, pcsrc_h, beq_h, bne_h,
                       aluop_h, illegal_h, busy_h};
  wire [19:0] act_z = {mem_req_z, irwrite_z, pcwrite_z, iord_z, memwrite_z, memtoreg_z,
                       regdst_z, regwrite_z, alusrca_z, alusrcb_z, pcsrc_z, beq_z, bne_z,
                       aluop_z, illegal_z, busy_z};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_vec(input string name, input int step, input logic [19:0] got,
                           input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%b exp=%b t=%0t", name, step, got, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cur[2];
  logic [5:0] lat[2];
  int         plan[2][3];
  int         plan_n[2];
  int         plan_i[2];
  bit         started = 1'b0;

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {O_R, O_J, O_BEQ, O_BNE, O_ADDI, O_SLTI, O_ANDI, O_ORI, O_LW, O_SW};
  endfunction

  function automatic logic [2:0] imm_class(input logic [5:0] o);
    case (o)
      O_ORI:   return A_OR;
      O_ANDI:  return A_AND;
      O_SLTI:  return A_SLT;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec(input int st, input logic [5:0] l, input logic [5:0] o,
                                          input logic rdy, input logic rst, input bit hs);
    logic mr, irw, pcw, io, mw, m2r, rd, rw, asa, bq, bn, ill, done;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    mr = 0; irw = 0; pcw = 0; io = 0; mw = 0; m2r = 0; rd = 0; rw = 0;
    asa = 0; bq = 0; bn = 0; ill = 0; asb = 2'b00; pcs = 2'b00; alu = A_ADD;
    done = hs ? rdy : 1'b1;
    case (st)
      S_F:   begin mr = 1; asb = 2'b01; irw = done; pcw = done; end
      S_D:   begin asb = 2'b11; ill = !is_legal(o); end
      S_MA:  begin asa = 1; asb = 2'b10; end
      S_MR:  begin mr = 1; io = 1; end
      S_MWB: begin rw = 1; m2r = 1; end
      S_MW:  begin mr = 1; io = 1; mw = done; end
      S_RX:  begin asa = 1; alu = A_NOUSE; end
      S_RWB: begin rw = 1; rd = 1; end
      S_BR:  begin asa = 1; alu = A_SUB; pcs = 2'b01; bq = (l == O_BEQ); bn = (l == O_BNE); end
      S_IX:  begin asa = 1; asb = 2'b10; alu = imm_class(l); end
      S_IWB: begin rw = 1; alu = imm_class(l); end
      S_J:   begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      mr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; bq = 0; bn = 0; ill = 0;
    end
    return {mr, irw, pcw, io, mw, m2r, rd, rw, asa, asb, pcs, bq, bn, alu, ill, 1'(st != S_F)};
  endfunction

  task automatic set_plan(input int h, input int a, input int b, input int c, input int n);
    plan[h][0] = a; plan[h][1] = b; plan[h][2] = c; plan_n[h] = n; plan_i[h] = 0;
  endtask

  task automatic advance(input int h);
    if (plan_i[h] < plan_n[h]) begin
      cur[h] = plan[h][plan_i[h]];
      plan_i[h]++;
    end else begin
      cur[h] = S_F;
    end
  endtask

  // One clock edge of the model for lane h (1 = handshaking, 0 = single-cycle).
  task automatic model_step(input int h, input logic rst, input logic [5:0] o, input logic r);
    logic done;
    done = (h == 1) ? r : 1'b1;
    if (rst) begin
      cur[h] = S_F; lat[h] = '0; plan_n[h] = 0; plan_i[h] = 0;
    end else begin
      case (cur[h])
        S_F: if (done) cur[h] = S_D;
        S_MR, S_MW: if (done) advance(h);
        S_D: begin
          lat[h] = o;
          case (o)
            O_LW:                           set_plan(h, S_MA, S_MR, S_MWB, 3);
            O_SW:                           set_plan(h, S_MA, S_MW, 0, 2);
            O_R:                            set_plan(h, S_RX, S_RWB, 0, 2);
            O_BEQ, O_BNE:                   set_plan(h, S_BR, 0, 0, 1);
            O_ADDI, O_ORI, O_ANDI, O_SLTI:  set_plan(h, S_IX, S_IWB, 0, 2);
            O_J:                            set_plan(h, S_J, 0, 0, 1);
            default:                        set_plan(h, 0, 0, 0, 0);
          endcase
          advance(h);
        end
        default: advance(h);
      endcase
    end
  endtask

  // ---------------- driver / compare ----------------
  logic [19:0] snap_h, snap_z;

  // Apply inputs, compare both lanes mid-cycle, then clock the model with the
  // same inputs the DUTs see at the rising edge.
  task automatic cycle(input logic rst, input logic [5:0] oh, input logic rh,
                       input logic [5:0] oz, input logic rz);
    reset = rst; op_h = oh; ready_h = rh; op_z = oz; ready_z = rz;
    @(negedge clk);
    snap_h = act_h;
    snap_z = act_z;
    if (started) begin
      check_vec("outs_hs1", cur[1], act_h, exp_vec(cur[1], lat[1], oh, rh, rst, 1'b1));
      check_vec("outs_hs0", cur[0], act_z, exp_vec(cur[0], lat[0], oz, rz, rst, 1'b0));
      n_checks++;
      if ((cur[1] == cur[0]) != (sdbg_h == sdbg_z)) begin
        n_fail++;
        $display("FAIL state_dbg_agree got=%0d/%0d steps=%0d/%0d", sdbg_h, sdbg_z, cur[1], cur[0]);
      end
    end
    @(posedge clk);
    model_step(1, rst, oh, rh);
    model_step(0, rst, oz, rz);
    if (rst) started = 1'b1;
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0: return O_R;    1: return O_J;    2: return O_BEQ;  3: return O_BNE;
      4: return O_ADDI; 5: return O_SLTI; 6: return O_ANDI; 7: return O_ORI;
      8: return O_LW;   9: return O_SW;   10: return O_LW;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    logic [5:0] oh, oz;
    logic rst;
    reset = 1'b1; op_h = '0; op_z = '0; ready_h = 1'b0; ready_z = 1'b0;
    cur[0] = S_F; cur[1] = S_F; lat[0] = '0; lat[1] = '0;
    plan_n[0] = 0; plan_n[1] = 0; plan_i[0] = 0; plan_i[1] = 0;
    @(posedge clk); #1;

    // Reset, then LW with mem_ready high every cycle.
    cycle(1, O_LW, 1, O_LW, 0);
    cycle(1, O_LW, 1, O_LW, 0);
    check_lit("reset_mem_req", int'(snap_h[B_MEMREQ]), 0);
    check_lit("reset_busy", int'(snap_h[B_BUSY]), 0);
    cycle(0, O_LW, 1, O_LW, 0);
    check_lit("lw_c1_irwrite", int'(snap_h[B_IRWRITE]), 1);
    cycle(0, O_LW, 1, O_LW, 0);
    cycle(0, O_LW, 1, O_LW, 0);
    cycle(0, O_LW, 1, O_LW, 0);
    check_lit("lw_c4_regwrite", int'(snap_h[B_REGWRITE]), 0);
    cycle(0, O_LW, 1, O_LW, 0);
    check_lit("lw_c5_regwrite", int'(snap_h[B_REGWRITE]), 1);
    check_lit("lw_c5_memtoreg", int'(snap_h[B_MEMTOREG]), 1);
    cycle(0, O_LW, 1, O_LW, 0);
    check_lit("lw_c6_busy", int'(snap_h[B_BUSY]), 0);

    // SW with three wait cycles in MEMWR.
    cycle(1, O_SW, 0, O_SW, 0);
    cycle(0, O_SW, 1, O_SW, 0);
    cycle(0, O_SW, 0, O_SW, 0);
    cycle(0, O_SW, 0, O_SW, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, O_SW, 0, O_SW, 0);
      check_lit($sformatf("sw_wait%0d_memwrite", i), int'(snap_h[B_MEMWRITE]), 0);
    end
    cycle(0, O_SW, 1, O_SW, 0);
    check_lit("sw_done_memwrite", int'(snap_h[B_MEMWRITE]), 1);
    cycle(0, O_SW, 1, O_SW, 0);
    check_lit("sw_after_busy", int'(snap_h[B_BUSY]), 0);

    // BNE then ORI.
    cycle(1, O_BNE, 1, O_BNE, 0);
    cycle(0, O_BNE, 1, O_BNE, 0);
    cycle(0, O_BNE, 1, O_BNE, 0);
    cycle(0, O_BNE, 1, O_BNE, 0);
    check_lit("bne_bne", int'(snap_h[B_BNE]), 1);
    check_lit("bne_beq", int'(snap_h[B_BEQ]), 0);
    check_lit("bne_aluop", int'(snap_h[4:2]), 6);
    check_lit("bne_pcsrc", int'(snap_h[8:7]), 1);
    cycle(0, O_ORI, 1, O_ORI, 0);
    cycle(0, O_ORI, 1, O_ORI, 0);
    cycle(0, O_ORI, 1, O_ORI, 0);
    check_lit("ori_ex_aluop", int'(snap_h[4:2]), 1);
    cycle(0, O_ORI, 1, O_ORI, 0);
    check_lit("ori_wb_aluop", int'(snap_h[4:2]), 1);

    // Illegal opcode.
    cycle(1, O_BAD, 1, O_BAD, 0);
    cycle(0, O_BAD, 1, O_BAD, 0);
    cycle(0, O_BAD, 1, O_BAD, 0);
    check_lit("ill_pulse", int'(snap_h[B_ILLEGAL]), 1);
    check_lit("ill_regwrite", int'(snap_h[B_REGWRITE]), 0);
    cycle(0, O_BAD, 1, O_BAD, 0);
    check_lit("ill_back_busy", int'(snap_h[B_BUSY]), 0);
    check_lit("ill_gone", int'(snap_h[B_ILLEGAL]), 0);

    // Reset while MEMRD is stalled.
    cycle(1, O_LW, 1, O_LW, 0);
    cycle(0, O_LW, 1, O_LW, 0);
    cycle(0, O_LW, 0, O_LW, 0);
    cycle(0, O_LW, 0, O_LW, 0);
    cycle(0, O_LW, 0, O_LW, 0);
    check_lit("memrd_stall_req", int'(snap_h[B_MEMREQ]), 1);
    cycle(1, O_LW, 0, O_LW, 0);
    check_lit("memrd_reset_req", int'(snap_h[B_MEMREQ]), 0);
    cycle(0, O_LW, 0, O_LW, 0);
    check_lit("memrd_reset_fetch", int'(snap_h[B_BUSY]), 0);

    // J on the single-cycle instance with mem_ready tied low.
    cycle(1, O_J, 0, O_J, 0);
    cycle(0, O_J, 1, O_J, 0);
    cycle(0, O_J, 1, O_J, 0);
    cycle(0, O_J, 1, O_J, 0);
    check_lit("j_hs0_pcwrite", int'(snap_z[B_PCWRITE]), 1);
    check_lit("j_hs0_pcsrc", int'(snap_z[8:7]), 2);
    cycle(0, O_J, 1, O_J, 0);
    check_lit("j_hs0_done", int'(snap_z[B_BUSY]), 0);

    // Random instruction streams; the opcode is held steady while in DECODE.
    oh = O_LW; oz = O_LW;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (cur[1] != S_D) oh = rand_op();
      if (cur[0] != S_D) oz = rand_op();
      cycle(rst, oh, 1'($urandom_range(0, 99) < 60), oz, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
